// File: rtl/slow_memory_responder_pkg.sv
// Shared testharness definitions for the slow-memory responder:
// FSM state encoding, LFSR seed and the default region depth.
package slow_memory_responder_pkg;

    // Slow-memory region is 0x200 bytes, organised as 32-bit words
    localparam int unsigned SLOW_MEMORY_SIZE      = 32'h200;
    localparam int unsigned SLOW_MEMORY_NUM_WORDS = SLOW_MEMORY_SIZE / 4;

    // Seed loaded into the latency LFSR whenever reset is asserted
    localparam logic [7:0] SLOW_MEMORY_LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } slow_memory_state_e;

endpackage

// File: rtl/slow_memory_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that picks per-transaction latencies
// for the slow-memory responder. Steps once per cycle while enable is high.
module slow_memory_lfsr
    import slow_memory_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] state
);

    // Shift left, feeding back the XOR of taps 8,6,5,4; reseed on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SLOW_MEMORY_LFSR_SEED;
        end else if (enable) begin
            state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
        end
    end

endmodule

// File: rtl/slow_memory_responder.sv
// OBI slave for the slow-memory region of the external crossbar. Every granted
// request gets exactly one response after a long latency so the external master
// path sees a wait-stated target. Only one transaction is outstanding at a time.
// Build option SLOW_MEMORY_RANDOM_LATENCY_EN: per-transaction latency drawn from
// an LFSR in 1..LATENCY instead of the fixed LATENCY.
module slow_memory_responder
    import slow_memory_responder_pkg::*;
#(
    parameter int unsigned NUM_WORDS = SLOW_MEMORY_NUM_WORDS,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS);

    slow_memory_state_e state_q;
    slow_memory_state_e state_d;
    logic [7:0]         count_q;
    logic [31:0]        resp_q;
    logic [7:0]         grant_latency;
    logic [IDX_W-1:0]   word_index;
    logic [31:0]        mem [NUM_WORDS];

    // Address wraps modulo the region and ignores the byte offset
    assign word_index = addr_i[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // A new request is accepted when idle or while the previous response is out
    assign gnt_o = req_i & rst_ni & ((state_q == IDLE) | (state_q == RESP));

`ifdef SLOW_MEMORY_RANDOM_LATENCY_EN
    localparam logic [7:0] LAT_MASK = 8'(LATENCY - 1);

    logic [7:0] lfsr_state;

    slow_memory_lfsr u_lfsr (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .enable (gnt_o),
        .state  (lfsr_state)
    );

    // Latency uses the LFSR value before this grant advances it
    assign grant_latency = 8'd1 + (lfsr_state & LAT_MASK);
`else
    assign grant_latency = 8'(LATENCY);
`endif

    // Next-state logic: grant starts a transaction, counter paces WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_o) begin
                    state_d = (grant_latency == 8'd1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (count_q == 8'd2) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (gnt_o) begin
                    state_d = (grant_latency == 8'd1) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latency counter and response register; reset drops any pending response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            resp_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (gnt_o) begin
                count_q <= grant_latency;
                resp_q  <= we_i ? 32'd0 : mem[word_index];
            end else if (state_q == WAIT) begin
                count_q <= count_q - 8'd1;
            end
        end
    end

    // Writes commit their enabled bytes at the grant edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[word_index][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = (state_q == RESP) ? resp_q : 32'd0;

endmodule

// File: tb/tb_slow_memory_responder.sv
// Directed self-checking bench for slow_memory_responder. Three instances with
// LATENCY 1, 4 and 8 share the request fields; 'sel' picks which one is driven.
// With SLOW_MEMORY_RANDOM_LATENCY_EN defined, only the reset and random-latency
// scenarios run.
module tb_slow_memory_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          sel;

    logic        gnt1, gnt4, gnt8;
    logic        rvalid1, rvalid4, rvalid8;
    logic [31:0] rdata1, rdata4, rdata8;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    slow_memory_responder #(.LATENCY(1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req && sel == 1), .gnt_o(gnt1),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid1), .rdata_o(rdata1)
    );

    slow_memory_responder #(.LATENCY(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req && sel == 4), .gnt_o(gnt4),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid4), .rdata_o(rdata4)
    );

    slow_memory_responder #(.LATENCY(8)) dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req && sel == 8), .gnt_o(gnt8),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid8), .rdata_o(rdata8)
    );

    // Route the selected instance's outputs to a common set of observation signals
    always_comb begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'd0;
        case (sel)
            1: begin gnt = gnt1; rvalid = rvalid1; rdata = rdata1; end
            4: begin gnt = gnt4; rvalid = rvalid4; rdata = rdata4; end
            8: begin gnt = gnt8; rvalid = rvalid8; rdata = rdata8; end
            default: ;
        endcase
    end

    // One transaction: request at a negedge, then count cycles until rvalid
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(negedge clk_i);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        n_total++;
        if (gnt !== 1'b1) $display("[TB] FAIL txn_gnt sel=%0d addr=%h: got %b want 1", sel, a, gnt);
        else n_pass++;
        @(negedge clk_i);
        req = 1'b0;
        lat = 1;
        while (rvalid !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        rd = rdata;
    endtask

    task automatic test_reset();
        int sels[3] = '{1, 4, 8};
        rst_ni = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; sel = 1;
        repeat (3) @(negedge clk_i);
        req = 1'b1;
        foreach (sels[i]) begin
            sel = sels[i];
            #1;
            n_total++;
            if (gnt !== 1'b0) $display("[TB] FAIL reset_gnt sel=%0d: got %b want 0", sel, gnt);
            else n_pass++;
            n_total++;
            if (rvalid !== 1'b0 || rdata !== 32'd0)
                $display("[TB] FAIL reset_resp sel=%0d: got rvalid=%b rdata=%h want 0/0", sel, rvalid, rdata);
            else n_pass++;
        end
        @(negedge clk_i);
        req = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        sel = 4;
        do_txn(1'b1, 32'h0000_000C, 4'hF, 32'hDEAD_BEEF, rd, lat);
        n_total++;
        if (lat !== 4 || rd !== 32'd0) $display("[TB] FAIL write_resp: got lat=%0d rdata=%h want 4/0", lat, rd);
        else n_pass++;
        do_txn(1'b0, 32'h0000_000C, 4'h0, 32'd0, rd, lat);
        n_total++;
        if (lat !== 4 || rd !== 32'hDEAD_BEEF) $display("[TB] FAIL read_resp: got lat=%0d rdata=%h want 4/deadbeef", lat, rd);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (rvalid !== 1'b0) $display("[TB] FAIL rvalid_pulse: got %b want 0", rvalid);
        else n_pass++;
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        int lat;
        sel = 4;
        do_txn(1'b1, 32'h0000_0014, 4'hF, 32'h1122_3344, rd, lat);
        do_txn(1'b1, 32'h0000_0014, 4'b0101, 32'hAABB_CCDD, rd, lat);
        do_txn(1'b0, 32'h0000_0014, 4'h0, 32'd0, rd, lat);
        n_total++;
        if (rd !== 32'h11BB_33DD) $display("[TB] FAIL byte_enable: got %h want 11bb33dd", rd);
        else n_pass++;
        do_txn(1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, rd, lat);
        n_total++;
        if (lat !== 4 || rd !== 32'd0) $display("[TB] FAIL be_zero_resp: got lat=%0d rdata=%h want 4/0", lat, rd);
        else n_pass++;
        do_txn(1'b0, 32'h0000_0017, 4'h0, 32'd0, rd, lat);
        n_total++;
        if (rd !== 32'h11BB_33DD) $display("[TB] FAIL be_zero_misaligned: got %h want 11bb33dd", rd);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int lat;
        sel = 4;
        do_txn(1'b1, 32'h0000_0208, 4'hF, 32'h0000_CAFE, rd, lat);
        do_txn(1'b0, 32'h0000_0008, 4'h0, 32'd0, rd, lat);
        n_total++;
        if (rd !== 32'h0000_CAFE) $display("[TB] FAIL wrap: got %h want 0000cafe", rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        sel = 1;
        for (int i = 0; i < 4; i++) do_txn(1'b1, 32'(i * 4), 4'hF, 32'h1000 + 32'(i), rd, lat);
        @(negedge clk_i);
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_total++;
                if (rvalid !== 1'b1 || rdata !== 32'h1000 + 32'(i - 1))
                    $display("[TB] FAIL b2b_resp%0d: got rvalid=%b rdata=%h want 1/%h", i - 1, rvalid, rdata, 32'h1000 + 32'(i - 1));
                else n_pass++;
            end
            addr = 32'(i * 4);
            #1;
            n_total++;
            if (gnt !== 1'b1) $display("[TB] FAIL b2b_gnt%0d: got %b want 1", i, gnt);
            else n_pass++;
            @(negedge clk_i);
        end
        req = 1'b0;
        n_total++;
        if (rvalid !== 1'b1 || rdata !== 32'h1003)
            $display("[TB] FAIL b2b_resp3: got rvalid=%b rdata=%h want 1/00001003", rvalid, rdata);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (rvalid !== 1'b0) $display("[TB] FAIL b2b_idle: got rvalid=%b want 0", rvalid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        int lat;
        int seen;
        sel = 8;
        do_txn(1'b1, 32'h0000_0028, 4'hF, 32'h5A5A_0001, rd, lat);
        n_total++;
        if (lat !== 8) $display("[TB] FAIL lat8_write: got lat=%0d want 8", lat);
        else n_pass++;
        @(negedge clk_i);
        req = 1'b1; we = 1'b0; addr = 32'h0000_0028;
        #1;
        n_total++;
        if (gnt !== 1'b1) $display("[TB] FAIL midwait_gnt: got %b want 1", gnt);
        else n_pass++;
        seen = 0;
        @(negedge clk_i);
        req = 1'b0;
        if (rvalid === 1'b1) seen++;
        @(negedge clk_i);
        if (rvalid === 1'b1) seen++;
        @(negedge clk_i);
        if (rvalid === 1'b1) seen++;
        rst_ni = 1'b0;
        @(negedge clk_i);
        req = 1'b1;
        #1;
        n_total++;
        if (gnt !== 1'b0) $display("[TB] FAIL midwait_reset_gnt: got %b want 0", gnt);
        else n_pass++;
        @(negedge clk_i);
        req = 1'b0;
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rvalid === 1'b1) seen++;
            @(negedge clk_i);
        end
        n_total++;
        if (seen !== 0) $display("[TB] FAIL midwait_dropped: got %0d rvalid cycles want 0", seen);
        else n_pass++;
        do_txn(1'b0, 32'h0000_0028, 4'h0, 32'd0, rd, lat);
        n_total++;
        if (lat !== 8 || rd !== 32'h5A5A_0001) $display("[TB] FAIL after_reset_read: got lat=%0d rdata=%h want 8/5a5a0001", lat, rd);
        else n_pass++;
    endtask

    task automatic test_random_latency();
        logic [31:0] rd;
        logic [7:0]  model;
        int lat;
        int exp_lat;
        int first_lats[64];
        logic [8:1] seen_vals;
        int out_of_range;
        sel = 8;
        model = 8'hA5;
        seen_vals = '0;
        out_of_range = 0;
        for (int i = 0; i < 1000; i++) begin
            exp_lat = 1 + int'(model & 8'h07);
            model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
            do_txn(1'b0, 32'(i * 4), 4'h0, 32'd0, rd, lat);
            if (i < 64) first_lats[i] = lat;
            if (lat >= 1 && lat <= 8) seen_vals[lat] = 1'b1;
            else out_of_range++;
            n_total++;
            if (lat !== exp_lat) $display("[TB] FAIL rand_lat%0d: got %0d want %0d", i, lat, exp_lat);
            else n_pass++;
        end
        n_total++;
        if (out_of_range !== 0 || seen_vals !== 8'hFF)
            $display("[TB] FAIL rand_coverage: got out_of_range=%0d seen=%b want 0/11111111", out_of_range, seen_vals);
        else n_pass++;
        test_reset();
        sel = 8;
        for (int i = 0; i < 64; i++) begin
            do_txn(1'b0, 32'(i * 4), 4'h0, 32'd0, rd, lat);
            n_total++;
            if (lat !== first_lats[i]) $display("[TB] FAIL rand_repeat%0d: got %0d want %0d", i, lat, first_lats[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
`ifdef SLOW_MEMORY_RANDOM_LATENCY_EN
        test_random_latency();
`else
        test_write_read();
        test_byte_enables();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/slow_memory_responder.md
# slow_memory_responder

OBI slave that implements the slow-memory region of the external crossbar (slave index 0, 0x200 bytes at the external-slave start address). Each granted request gets exactly one response after a deliberately long, configurable latency, so the MCU's external-master path is exercised against a non-zero-wait-state target. It sits on the testbench side of the external crossbar and terminates the single external slave port.

## Interface
- NUM_WORDS, 128: depth in 32-bit words (0x200 bytes / 4); power of two.
- LATENCY, 4: grant-to-rvalid cycles, 1..255. In random mode it is the maximum latency and must be a power of two.
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous to clk_i, active-low
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant (combinational)
- addr_i  in  32  byte address; only bits [$clog2(NUM_WORDS)+1:2] are used
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  read data; 0 for write responses

## Operation
- States: IDLE, WAIT, RESP.
  - gnt_o = req_i & rst_ni & (state==IDLE | state==RESP).
  - At most one outstanding transaction.
- On grant, captured at the clock edge:
  - Writes commit their enabled bytes to memory.
  - Reads latch mem[index] into a response register.
  - Write responses latch 0.
  - Counter loads the latency L.
  - Next state is RESP if L==1, otherwise WAIT.
- WAIT: counter decrements each cycle. When the counter reaches 1, the next state is RESP.
- RESP: rvalid_o=1 and rdata_o = response register.
  - A grant in this same cycle starts the next transaction (back-to-back).
  - Otherwise the next state is IDLE.
- Upper address bits are ignored, so the address wraps modulo NUM_WORDS*4. Misaligned address bits [1:0] are ignored.
- be_i=0 on a write updates nothing but still returns a response.
- A read that follows a write to the same word sees the new data, because the write commits at its grant edge.
- Memory contents are not reset.

## Timing
- Grant in cycle T → rvalid_o high in cycle T+L for exactly one cycle.
- Maximum throughput is one transaction per L cycles.
- Reset values: state IDLE, rvalid_o 0, rdata_o 0, counter 0, gnt_o 0 while rst_ni=0.
- Reset asserted mid-transaction: the pending response is dropped and no rvalid_o is issued. Writes granted before the reset remain in memory.
- req_i deasserted while in WAIT: no effect; the response is still delivered.

## Configuration
- SLOW_MEMORY_RANDOM_LATENCY_EN undefined:
  - Every transaction uses L = LATENCY.
- SLOW_MEMORY_RANDOM_LATENCY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset, advances once per grant.
  - L = 1 + (lfsr & (LATENCY-1)), computed from the LFSR value before that grant's advance.
  - L therefore ranges over 1..LATENCY.

## Structure
- Shared testharness package holds:
  - state enum slow_memory_state_e;
  - SLOW_MEMORY_LFSR_SEED = 8'hA5;
  - the default NUM_WORDS, derived as SLOW_MEMORY_SIZE/4.
- Sub-module slow_memory_lfsr (enable, 8-bit state output) holds the LFSR. It is instantiated only under the macro.
- The memory array and the FSM stay in the top module.

## Test plan
- LATENCY=4, fixed: write 0xDEADBEEF to word 3 (be=4'hF) → gnt in T, rvalid in T+4 with rdata 0. A subsequent read of word 3 → rdata 0xDEADBEEF exactly 4 cycles after its grant.
- Byte enables: word 5 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- Back-to-back, LATENCY=1: req_i held high for 4 reads → gnt_o high every cycle, rvalid_o high every cycle from T+1, data in request order.
- Wrap: write 0x0000CAFE at byte offset 0x200+0x8 → a read at offset 0x8 returns 0x0000CAFE.
- Reset mid-WAIT (LATENCY=8; rst_ni low at T+3 for 2 cycles) → no rvalid_o ever for that request, gnt_o 0 during reset, next request served normally. A write granted before the reset is still readable afterwards.
- Random mode, LATENCY=8: 1000 reads → every latency within 1..8, all 8 values observed, sequence identical across two runs with the same reset.
